// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator; define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait edges
module apb_master #(
  parameter int ADDR_width     = 4,
  parameter int DATA_width     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  P_clk,
  input  logic                  P_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_width-1:0] cmd_addr,
  input  logic [DATA_width-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_width-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  P_sel,
  output logic                  P_enable,
  output logic                  P_write,
  output logic [ADDR_width-1:0] P_addr,
  output logic [DATA_width-1:0] P_wdata,
  input  logic [DATA_width-1:0] P_rdata,
  input  logic                  P_ready,
  input  logic                  P_slverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`else
  assign rsp_timeout = 1'b0;
`endif
  always_ff @(posedge P_clk) begin
    if (P_reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      P_sel      <= 1'b0;
      P_enable   <= 1'b0;
      P_write    <= 1'b0;
      P_addr     <= '0;
      P_wdata    <= '0;
`ifdef APB_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          P_write   <= cmd_write;
          P_addr    <= cmd_addr;
          P_wdata   <= cmd_wdata;
          P_sel     <= 1'b1;
          cmd_ready <= 1'b0;
          state     <= SETUP;
        end
        SETUP: begin
          P_enable <= 1'b1;
          state    <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        ACCESS: if (P_ready) begin
          rsp_valid  <= 1'b1;
          rsp_slverr <= P_slverr;
          if (!P_write) rsp_rdata <= P_rdata;
          P_sel      <= 1'b0;
          P_enable   <= 1'b0;
          cmd_ready  <= 1'b1;
          state      <= IDLE;
`ifdef APB_TIMEOUT_EN
          rsp_timeout <= 1'b0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          // this is the TIMEOUT_CYCLES-th consecutive wait edge: abort with error
          rsp_valid   <= 1'b1;
          rsp_slverr  <= 1'b1;
          rsp_timeout <= 1'b1;
          P_sel       <= 1'b0;
          P_enable    <= 1'b0;
          cmd_ready   <= 1'b1;
          state       <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: vector table, reset/timeout sequences and randomized transfers against a transaction-level model
module tb_apb_master;
  logic P_clk = 1'b0, P_reset = 1'b1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [3:0] cmd_addr = 0, P_addr;
  logic [7:0] cmd_wdata = 0, rsp_rdata, P_wdata, P_rdata = 0;
  logic rsp_valid, rsp_slverr, rsp_timeout, P_sel, P_enable, P_write;
  logic P_ready = 0, P_slverr = 0;
  int vectors = 0, miscompares = 0;
  logic [7:0] last_rd;

  apb_master #(.ADDR_width(4), .DATA_width(8), .TIMEOUT_CYCLES(4)) dut (
    .P_clk(P_clk), .P_reset(P_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout), .P_sel(P_sel), .P_enable(P_enable), .P_write(P_write),
    .P_addr(P_addr), .P_wdata(P_wdata), .P_rdata(P_rdata), .P_ready(P_ready),
    .P_slverr(P_slverr));

  always #5 P_clk = ~P_clk;

  typedef struct {
    logic w; logic [3:0] a; logic [7:0] d; int waits;
    logic [7:0] rd; logic se; logic [7:0] exp_rd; logic exp_se;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge P_clk);
    @(negedge P_clk);
  endtask

  task automatic scramble();
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = 4'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  task automatic xfer(input logic w, input logic [3:0] a, input logic [7:0] d, input int waits,
                      input logic [7:0] rd, input logic se, input logic [7:0] exp_rd, input logic exp_se);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_sel", {P_sel, P_enable}, 0);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    cyc();
    scramble();
    chk("setup_phase", {P_sel, P_enable, cmd_ready}, 3'b100);
    chk("pulse_once", rsp_valid, 0);
    cyc();
    for (int i = 0; i <= waits; i++) begin
      chk("access_bus", {P_sel, P_enable, P_write, P_addr, P_wdata}, {1'b1, 1'b1, w, a, d});
      chk("access_norsp", rsp_valid, 0);
      scramble();
      P_ready  = (i == waits);
      P_rdata  = (i == waits) ? rd : 8'($urandom);
      P_slverr = (i == waits) ? se : 1'($urandom);
      cyc();
    end
    P_ready = 0; cmd_valid = 0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_slverr", rsp_slverr, exp_se);
    chk("rsp_timeout", rsp_timeout, 0);
    chk("done_bus", {P_sel, P_enable, cmd_ready}, 3'b001);
    chk("bus_hold", {P_write, P_addr, P_wdata}, {w, a, d});
  endtask

  task automatic start_to_access(input logic w, input logic [3:0] a, input logic [7:0] d);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    cyc();
    cmd_valid = 0;
    cyc();
    chk("in_access", {P_sel, P_enable}, 2'b11);
  endtask

  task automatic reset_in_access();
    P_reset = 1;
    cyc();
    chk("rst_bus", {P_sel, P_enable, rsp_valid}, 0);
    chk("rst_ready", cmd_ready, 1);
    P_reset = 0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_no_rsp", {rsp_valid, P_sel, cmd_ready}, 3'b001);
      cyc();
    end
    last_rd = 8'h00;
  endtask

  vec_t tbl[6];
  initial begin
    tbl[0] = '{1'b1, 4'h3, 8'hA5, 0, 8'h77, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 4'hF, 8'h00, 2, 8'h5C, 1'b0, 8'h5C, 1'b0};
    tbl[2] = '{1'b0, 4'h7, 8'h00, 1, 8'h3C, 1'b1, 8'h3C, 1'b1};
    tbl[3] = '{1'b1, 4'h1, 8'h11, 0, 8'h00, 1'b0, 8'h3C, 1'b0};
    tbl[4] = '{1'b0, 4'h1, 8'h00, 0, 8'h11, 1'b0, 8'h11, 1'b0};
    tbl[5] = '{1'b1, 4'h2, 8'h44, 3, 8'hFF, 1'b1, 8'h11, 1'b1};
    cyc();
    cyc();
    chk("reset_ready", cmd_ready, 1);
    chk("reset_outs", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, P_sel, P_enable, P_write, P_addr, P_wdata}, 0);
    P_reset = 0;
    cyc();
    foreach (tbl[i])
      xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].waits, tbl[i].rd, tbl[i].se, tbl[i].exp_rd, tbl[i].exp_se);
    last_rd = 8'h11;
    cyc();
    start_to_access(1'b0, 4'h9, 8'h00);
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_wait", {P_sel, P_enable, rsp_valid}, 3'b110);
      P_slverr = 1'($urandom);
      cyc();
    end
    chk("to_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, 3'b111);
    chk("to_rdata", rsp_rdata, last_rd);
    chk("to_idle", {P_sel, P_enable, cmd_ready}, 3'b001);
    cyc();
    chk("to_pulse", rsp_valid, 0);
    start_to_access(1'b1, 4'hC, 8'h5A);
`else
    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        if ({P_sel, P_enable, rsp_valid} !== 3'b110) bad++;
        P_slverr = 1'($urandom);
        cyc();
      end
      chk("no_timeout_cycles_bad", bad, 0);
    end
`endif
    reset_in_access();
    for (int n = 0; n < 200; n++) begin
      logic w, se;
      logic [3:0] a;
      logic [7:0] d, rd, exp_rd;
      int waits;
      w = 1'($urandom); a = 4'($urandom); d = 8'($urandom); rd = 8'($urandom);
      se = ($urandom_range(0, 3) == 0);
      waits = $urandom_range(0, 3);
      exp_rd = w ? last_rd : rd;
      xfer(w, a, d, waits, rd, se, exp_rd, se);
      last_rd = exp_rd;
      if ($urandom_range(0, 1) == 1) cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that turns single-beat command requests from local logic into APB SETUP/ACCESS transfers.
- Drives the shared APB bus towards the team's memory-backed APB slaves.
- Returns read data and slave error through a one-cycle response pulse.
- One outstanding transfer at a time. All bus outputs are registered.

Parameters:
ADDR_width, 4, width of P_addr and cmd_addr
DATA_width, 8, width of P_wdata, P_rdata, cmd_wdata, rsp_rdata
TIMEOUT_CYCLES, 16, maximum ACCESS cycles spent waiting for P_ready; used only when APB_TIMEOUT_EN is defined; must be >= 1

Ports:
P_clk  input  1  clock; all logic on rising edge
P_reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  master can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_width  transfer address
cmd_wdata  input  DATA_width  write data
rsp_valid  output  1  one-cycle pulse: transfer completed
rsp_rdata  output  DATA_width  read data captured at completion
rsp_slverr  output  1  P_slverr captured at completion (or timeout error)
rsp_timeout  output  1  completion was a timeout abort
P_sel  output  1  APB select
P_enable  output  1  APB enable
P_write  output  1  APB direction
P_addr  output  ADDR_width  APB address
P_wdata  output  DATA_width  APB write data
P_rdata  input  DATA_width  APB read data
P_ready  input  1  APB ready
P_slverr  input  1  APB slave error

Behaviour:
- Reset (P_reset=1 at a rising edge):
  - State goes to IDLE.
  - All outputs clear to 0, except cmd_ready = 1 in IDLE, so it reads 1 on the cycle after reset.
  - Timeout counter clears to 0.
- Reset mid-transfer aborts immediately: P_sel and P_enable drop on the next cycle and no response is issued.
- FSM states:
  - IDLE:
    - cmd_ready = 1; P_sel = 0; P_enable = 0.
    - On an edge with cmd_valid = 1, register cmd_write, cmd_addr and cmd_wdata onto P_write, P_addr and P_wdata, then go to SETUP.
  - SETUP:
    - cmd_ready = 0; P_sel = 1; P_enable = 0.
    - Unconditionally go to ACCESS on the next edge.
  - ACCESS:
    - P_sel = 1; P_enable = 1.
    - On an edge with P_ready = 1:
      - rsp_valid <= 1 for exactly one cycle.
      - rsp_slverr <= P_slverr.
      - rsp_rdata <= P_rdata if P_write = 0; otherwise rsp_rdata holds its previous value.
      - rsp_timeout <= 0.
      - Go to IDLE.
    - If P_ready = 0, stay in ACCESS.
- Latency:
  - Command accepted at edge N: SETUP during cycle N+1, ACCESS from cycle N+2.
  - With zero wait states, rsp_valid is high in cycle N+3.
  - Each P_ready-low cycle adds one cycle of latency.
- Throughput: minimum 3 cycles per transfer. IDLE is always visited, so P_sel deasserts for at least one cycle between transfers.
- Bus stability:
  - P_addr, P_write and P_wdata are constant from SETUP through the end of ACCESS.
  - After completion they keep their last values; they change only on command acceptance.
- cmd_* inputs are ignored outside IDLE. No command queuing.
- rsp_valid has no backpressure; the consumer must take it when it pulses.
- P_slverr is sampled only on the completing edge; it is ignored while P_ready = 0.
- P_rdata is ignored on write completions.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A counter increments on each ACCESS-state edge with P_ready = 0, and clears when entering ACCESS.
  - When the counter reaches TIMEOUT_CYCLES (i.e. the TIMEOUT_CYCLES-th consecutive P_ready-low ACCESS edge):
    - rsp_valid <= 1, rsp_slverr <= 1, rsp_timeout <= 1.
    - rsp_rdata is unchanged.
    - P_sel and P_enable drop; go to IDLE.
  - If P_ready = 1 on the same edge the limit is reached, the normal completion wins.
- APB_TIMEOUT_EN undefined:
  - No counter logic.
  - rsp_timeout is tied to 0.
  - ACCESS waits indefinitely for P_ready.

Test Plan:
- Write, zero wait:
  - Stimulus: cmd write, addr 4'h3, wdata 8'hA5; slave drives P_ready = 1 in ACCESS.
  - Required: P_sel=1/P_enable=0 for 1 cycle, then P_sel=1/P_enable=1 with P_addr=3, P_wdata=A5, P_write=1; rsp_valid in cycle N+3; rsp_slverr=0.
- Read with 2 wait states:
  - Stimulus: slave holds P_ready=0 for 2 ACCESS cycles, then 1 with P_rdata=8'h5C; cmd read, addr 4'hF.
  - Required: ACCESS lasts 3 cycles; rsp_rdata=5C; rsp_valid pulses once at N+5; P_addr stays F throughout.
- Slave error:
  - Stimulus: read completes with P_slverr=1.
  - Required: rsp_slverr=1; rsp_timeout=0; next transfer starts from IDLE with cmd_ready=1.
- Back-to-back commands:
  - Stimulus: cmd_valid held high with write 1→8'h11, then read 1; slave returns P_rdata=11.
  - Required: P_sel low for exactly one cycle between transfers; second rsp_rdata=11.
- Reset in ACCESS:
  - Stimulus: assert P_reset while P_ready=0.
  - Required: next cycle P_sel=0, P_enable=0, rsp_valid=0, cmd_ready=1 after reset releases; no response pulse.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: P_ready held 0.
  - Required: after 4 ACCESS edges, rsp_valid=1, rsp_slverr=1, rsp_timeout=1, return to IDLE.
  - Without the macro: ACCESS persists for 100 cycles with no response.
